// File: rtl/debounce_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank_if
// Description : Button-side bundle of debounce_bank: raw levels in, debounced
//               levels and event pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_bank_if #(
   parameter int N = 4
);
   logic [N-1:0] pbi;
   logic [N-1:0] pbo;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] rpt;

   modport master (output pbi, input pbo, input rise, input fall, input rpt);
   modport slave  (input pbi, output pbo, output rise, output fall, output rpt);
endinterface
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : N independent pushbutton conditioners: 2-flop synchroniser,
//               stability-window debounce, press/release pulses, auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
   parameter int N             = 4,
   parameter int LIMIT         = 1000000,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic           clk,
   input  logic           reset,
   debounce_bank_if.slave bus
);
   localparam int CNT_W    = $clog2(LIMIT);
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam bit RPT_EN   = (REPEAT_DELAY > 0);

   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(LIMIT - 1);
   // Hold counter targets: it has counted D-1 / P-1 edges when the pulse is due.
   localparam logic [HOLD_W-1:0] HOLD_FIRST  = HOLD_W'(RPT_EN ? REPEAT_DELAY - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD - 1);

   logic [N-1:0] w_pbo;
   logic [N-1:0] w_rise;
   logic [N-1:0] w_fall;
   logic [N-1:0] w_rpt;

   for (genvar g = 0; g < N; g++) begin : g_ch
      logic [1:0]        r_sync;
      logic [CNT_W-1:0]  r_cnt;
      logic [HOLD_W-1:0] r_hold;
      logic              r_rep;
      logic              r_pbo;
      logic              r_rise;
      logic              r_fall;
      logic              r_rpt;

      logic              w_s;
      logic              w_accept;
      logic              w_hit;
      logic [HOLD_W-1:0] w_target;

      assign w_s      = r_sync[1];
      assign w_accept = (w_s != r_pbo) && (r_cnt == CNT_LAST);
      assign w_target = r_rep ? HOLD_PERIOD : HOLD_FIRST;
      // Suppressed on the release edge so rpt never lands in the fall cycle.
      assign w_hit    = RPT_EN && r_pbo && !w_accept && (r_hold == w_target);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_pbo  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end else begin
            r_sync <= {r_sync[0], bus.pbi[g]};
            r_rise <= w_accept && w_s;
            r_fall <= w_accept && !w_s;
            if (w_s == r_pbo) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_pbo <= w_s;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
            r_rpt  <= 1'b0;
         end else begin
            r_rpt <= w_hit;
            if (w_accept || !r_pbo) begin
               r_hold <= '0;
               r_rep  <= 1'b0;
            end else if (w_hit) begin
               r_hold <= '0;
               r_rep  <= 1'b1;
            end else if (RPT_EN) begin
               r_hold <= r_hold + 1'b1;
            end
         end
      end

      assign w_pbo[g]  = r_pbo;
      assign w_rise[g] = r_rise;
      assign w_fall[g] = r_fall;
      assign w_rpt[g]  = r_rpt;
   end

   assign bus.pbo  = w_pbo;
   assign bus.rise = w_rise;
   assign bus.fall = w_fall;
   assign bus.rpt  = w_rpt;
endmodule
`default_nettype wire
